timer_regs: RTL and testbench

- Register bank and counting core directly downstream of the APB slave interface.
- Decodes the single-cycle read/write strobes, byte enables and address from the interface, and holds the control, counter, compare and interrupt registers.
- Runs a 64-bit up-counter with optional power-of-two prescaler.
- Returns read data and a slave-error flag combinationally, and drives a level interrupt.

---
 rtl/timer_regs_if.sv | 33 +++
 rtl/timer_regs.sv | 248 ++++++++++++++++++++++++
 tb/tb_timer_regs.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : timer_regs_if
// Description : Register-access bus between the APB slave front end and the
//               timer register bank (strobes, address, data, byte enables,
//               read data and slave error).
// Revision    : 1.0 - initial release
// ============================================================================
interface timer_regs_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic                  reg_wen;
    logic                  reg_ren;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   byte_en;
    logic [DATA_W-1:0]     rdata;
    logic                  error;

    // Front end issuing register accesses
    modport master (
        output reg_wen, reg_ren, addr, wdata, byte_en,
        input  rdata, error
    );

    // Register bank answering the accesses
    modport slave (
        input  reg_wen, reg_ren, addr, wdata, byte_en,
        output rdata, error
    );
endinterface
`default_nettype wire

// File: rtl/timer_regs.sv
`default_nettype none
// ============================================================================
// Module      : timer_regs
// Description : Timer register bank and counting core. Holds control, 64-bit
//               counter, compare and interrupt registers, runs the
//               power-of-two prescaler and drives a registered level
//               interrupt. Read data and write error are combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_regs #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int MAX_DIV = 8
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    timer_regs_if.slave     bus,
    output logic            tim_int
);

    localparam int                  c_WORD_W  = ADDR_W - 2;
    localparam int                  c_NBYTES  = DATA_W / 8;
    localparam logic [c_WORD_W-1:0] c_TCR     = c_WORD_W'(0);
    localparam logic [c_WORD_W-1:0] c_TDR0    = c_WORD_W'(1);
    localparam logic [c_WORD_W-1:0] c_TDR1    = c_WORD_W'(2);
    localparam logic [c_WORD_W-1:0] c_TCMP0   = c_WORD_W'(3);
    localparam logic [c_WORD_W-1:0] c_TCMP1   = c_WORD_W'(4);
    localparam logic [c_WORD_W-1:0] c_TIER    = c_WORD_W'(5);
    localparam logic [c_WORD_W-1:0] c_TISR    = c_WORD_W'(6);
    localparam logic [3:0]          c_MAX_DIV = 4'(MAX_DIV);

    // Replace only the byte lanes whose strobe is set
    function automatic logic [DATA_W-1:0] f_merge(
        input logic [DATA_W-1:0]   old_v,
        input logic [DATA_W-1:0]   new_v,
        input logic [c_NBYTES-1:0] be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < c_NBYTES; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_timer_en;
    logic        r_div_en;
    logic [3:0]  r_div_val;
    logic [7:0]  r_div_cnt;
    logic [63:0] r_cnt;
    logic [63:0] r_cmp;
    logic        r_int_en;
    logic        r_int_st;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] w_word;
    logic                w_unused_addr;
    logic                w_wr_tcr;
    logic                w_wr_tdr0;
    logic                w_wr_tdr1;
    logic                w_wr_tcmp0;
    logic                w_wr_tcmp1;
    logic                w_wr_tier;
    logic                w_wr_tisr;

    assign w_word        = bus.addr[ADDR_W-1:2];
    assign w_unused_addr = ^bus.addr[1:0];
    assign w_wr_tcr      = bus.reg_wen && (w_word == c_TCR);
    assign w_wr_tdr0     = bus.reg_wen && (w_word == c_TDR0);
    assign w_wr_tdr1     = bus.reg_wen && (w_word == c_TDR1);
    assign w_wr_tcmp0    = bus.reg_wen && (w_word == c_TCMP0);
    assign w_wr_tcmp1    = bus.reg_wen && (w_word == c_TCMP1);
    assign w_wr_tier     = bus.reg_wen && (w_word == c_TIER);
    assign w_wr_tisr     = bus.reg_wen && (w_word == c_TISR);

    // ------------------------------------------------------------------
    // TCR write legality: the merged value is checked as a whole and the
    // entire write is dropped if any part of it is illegal.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_tcr_cur;
    logic [DATA_W-1:0] w_tcr_new;
    logic [3:0]        w_new_div_val;
    logic              w_new_div_en;
    logic              w_new_timer_en;
    logic              w_unused_tcr;
    logic              w_tcr_illegal;
    logic              w_tcr_accept;

    assign w_tcr_cur      = {20'd0, r_div_val, 6'd0, r_div_en, r_timer_en};
    assign w_tcr_new      = f_merge(w_tcr_cur, bus.wdata, bus.byte_en);
    assign w_new_div_val  = w_tcr_new[11:8];
    assign w_new_div_en   = w_tcr_new[1];
    assign w_new_timer_en = w_tcr_new[0];
    assign w_unused_tcr   = ^{w_tcr_new[31:12], w_tcr_new[7:2]};

    assign w_tcr_illegal  = (w_new_div_val > c_MAX_DIV) ||
                            (r_timer_en && ((w_new_div_en  != r_div_en) ||
                                            (w_new_div_val != r_div_val)));
    assign w_tcr_accept   = w_wr_tcr && !w_tcr_illegal;
    assign bus.error      = w_wr_tcr && w_tcr_illegal;

    // ------------------------------------------------------------------
    // Prescaler: terminal count is 2^div_val - 1 (9 bits so div_val=8 fits)
    // ------------------------------------------------------------------
    logic [8:0] w_div_term;
    logic       w_tick;
    logic       w_inc;

    assign w_div_term = (9'd1 << r_div_val) - 9'd1;
    assign w_tick     = !r_div_en || ({1'b0, r_div_cnt} == w_div_term);
    assign w_inc      = r_timer_en && w_tick;

    // ------------------------------------------------------------------
    // Counter next value: a software load wins over the increment
    // ------------------------------------------------------------------
    logic [63:0] w_cnt_next;

    // Load written bytes over the pre-increment value, else count on tick
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_wr_tdr0 || w_wr_tdr1) begin
            if (w_wr_tdr0) begin
                w_cnt_next[31:0] = f_merge(r_cnt[31:0], bus.wdata, bus.byte_en);
            end
            if (w_wr_tdr1) begin
                w_cnt_next[63:32] = f_merge(r_cnt[63:32], bus.wdata, bus.byte_en);
            end
        end else if (w_inc) begin
            w_cnt_next = r_cnt + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Compare and interrupt status
    // ------------------------------------------------------------------
    logic w_match;
    logic w_int_clr;

    assign w_match   = (r_cnt == r_cmp);
    assign w_int_clr = w_wr_tisr && bus.byte_en[0] && bus.wdata[0];

    // Control register update on accepted TCR writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer_en <= 1'b0;
            r_div_en   <= 1'b0;
            r_div_val  <= 4'd1;
        end else if (w_tcr_accept) begin
            r_timer_en <= w_new_timer_en;
            r_div_en   <= w_new_div_en;
            r_div_val  <= w_new_div_val;
        end
    end

    // Prescaler count, restarted when stopped or when TCR is rewritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= 8'd0;
        end else if (!r_timer_en || w_tcr_accept || !r_div_en || w_tick) begin
            r_div_cnt <= 8'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
        end
    end

    // 64-bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 64'd0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Compare value, byte-writable in both halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp <= {64{1'b1}};
        end else begin
            if (w_wr_tcmp0) begin
                r_cmp[31:0] <= f_merge(r_cmp[31:0], bus.wdata, bus.byte_en);
            end
            if (w_wr_tcmp1) begin
                r_cmp[63:32] <= f_merge(r_cmp[63:32], bus.wdata, bus.byte_en);
            end
        end
    end

    // Interrupt enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_en <= 1'b0;
        end else if (w_wr_tier && bus.byte_en[0]) begin
            r_int_en <= bus.wdata[0];
        end
    end

    // Interrupt status: a compare match beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_st <= 1'b0;
        end else if (w_match) begin
            r_int_st <= 1'b1;
        end else if (w_int_clr) begin
            r_int_st <= 1'b0;
        end
    end

    // Registered interrupt level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tim_int <= 1'b0;
        end else begin
            tim_int <= r_int_en && r_int_st;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rd;

    // Select register by word offset; unmapped words read zero
    always_comb begin
        w_rd = '0;
        case (w_word)
            c_TCR:   w_rd = w_tcr_cur;
            c_TDR0:  w_rd = r_cnt[31:0];
            c_TDR1:  w_rd = r_cnt[63:32];
            c_TCMP0: w_rd = r_cmp[31:0];
            c_TCMP1: w_rd = r_cmp[63:32];
            c_TIER:  w_rd = {31'd0, r_int_en};
            c_TISR:  w_rd = {31'd0, r_int_st};
            default: w_rd = '0;
        endcase
    end

    assign bus.rdata = bus.reg_ren ? w_rd : '0;

endmodule
`default_nettype wire

// File: tb/tb_timer_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer_regs
// Description : Directed self-checking bench for timer_regs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_regs;

    logic clk = 1'b0;
    logic rst_n;
    logic tim_int;
    int   checks = 0;
    int   errors = 0;

    timer_regs_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    timer_regs #(.ADDR_W(12), .DATA_W(32), .MAX_DIV(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .tim_int (tim_int)
    );

    always #5 clk = ~clk;

    // Drive one write cycle; error is sampled before the capturing edge.
    // Called and returns 1ns after a rising edge.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic err);
        bus.reg_wen = 1'b1;
        bus.addr    = a;
        bus.wdata   = d;
        bus.byte_en = be;
        #1 err = bus.error;
        @(posedge clk);
        #1;
        bus.reg_wen = 1'b0;
        bus.byte_en = 4'h0;
    endtask

    // Combinational read, no clock edge consumed
    task automatic do_read(input logic [11:0] a, output logic [31:0] d);
        bus.reg_ren = 1'b1;
        bus.addr    = a;
        #1 d = bus.rdata;
        bus.reg_ren = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] a_tab [8] = '{12'h000, 12'h004, 12'h008, 12'h00C,
                                   12'h010, 12'h014, 12'h018, 12'h020};
        logic [31:0] e_tab [8] = '{32'h0000_0100, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                   32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
        logic [31:0] d;
        rst_n       = 1'b0;
        bus.reg_wen = 1'b0;
        bus.reg_ren = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.byte_en = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tim_int !== 1'b0) begin
            errors++; $display("FAIL reset_tim_int: got %b expected 0", tim_int);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            do_read(a_tab[i], d);
            checks++;
            if (d !== e_tab[i]) begin
                errors++;
                $display("FAIL reset_read[%h]: got %h expected %h", a_tab[i], d, e_tab[i]);
            end
        end
        bus.reg_ren = 1'b1; bus.addr = 12'h000; #1;
        checks++;
        if (bus.error !== 1'b0) begin
            errors++; $display("FAIL read_error: got %b expected 0", bus.error);
        end
        bus.reg_ren = 1'b0; #1;
        checks++;
        if (bus.rdata !== 32'h0) begin
            errors++; $display("FAIL rdata_idle: got %h expected 0", bus.rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_strobes();
        logic        err;
        logic [31:0] d;
        do_write(12'h00C, 32'h1234_5678, 4'b0101, err);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL bytes_error: got %b expected 0", err);
        end
        do_read(12'h00C, d);
        checks++;
        if (d !== 32'hFF34_FF78) begin
            errors++; $display("FAIL bytes_tcmp0: got %h expected ff34ff78", d);
        end
    endtask

    task automatic test_prescaler();
        logic        err;
        logic [31:0] d;
        do_write(12'h000, 32'h0000_0203, 4'hF, err);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL presc_error: got %b expected 0", err);
        end
        repeat (40) @(posedge clk);
        #1;
        do_read(12'h004, d);
        checks++;
        if (!(d >= 32'd9 && d <= 32'd11)) begin
            errors++; $display("FAIL presc_count: got %0d expected 10 (+/-1)", d);
        end
    endtask

    task automatic test_illegal_tcr();
        logic        err;
        logic [31:0] d;
        do_write(12'h000, 32'h0000_0903, 4'hF, err);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL div9_error: got %b expected 1", err);
        end
        do_read(12'h000, d);
        checks++;
        if (d !== 32'h0000_0203) begin
            errors++; $display("FAIL div9_tcr: got %h expected 00000203", d);
        end
        do_write(12'h000, 32'h0000_0303, 4'hF, err);
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL running_error: got %b expected 1", err);
        end
        do_read(12'h000, d);
        checks++;
        if (d !== 32'h0000_0203) begin
            errors++; $display("FAIL running_tcr: got %h expected 00000203", d);
        end
        do_write(12'h014, 32'h0000_0902, 4'hF, err);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL other_addr_error: got %b expected 0", err);
        end
        do_write(12'h000, 32'h0000_0202, 4'hF, err);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL stop_error: got %b expected 0", err);
        end
        do_read(12'h000, d);
        checks++;
        if (d !== 32'h0000_0202) begin
            errors++; $display("FAIL stop_tcr: got %h expected 00000202", d);
        end
        do_write(12'h004, 32'h0000_0055, 4'hF, err);
        repeat (10) @(posedge clk);
        #1;
        do_read(12'h004, d);
        checks++;
        if (d !== 32'h0000_0055) begin
            errors++; $display("FAIL stop_hold: got %h expected 00000055", d);
        end
    endtask

    task automatic test_wrap();
        logic        err;
        logic [31:0] d;
        logic [31:0] d2;
        do_write(12'h004, 32'hFFFF_FFFE, 4'hF, err);
        do_write(12'h008, 32'hFFFF_FFFF, 4'hF, err);
        do_write(12'h00C, 32'h0, 4'hF, err);
        do_write(12'h010, 32'h0, 4'hF, err);
        do_write(12'h014, 32'h1, 4'hF, err);
        do_write(12'h000, 32'h0000_0001, 4'hF, err);
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL wrap_en_error: got %b expected 0", err);
        end
        @(posedge clk); #1;
        do_read(12'h004, d);
        do_read(12'h008, d2);
        checks++;
        if ({d2, d} !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL wrap_max: got %h%h expected ffffffffffffffff", d2, d);
        end
        @(posedge clk); #1;
        do_read(12'h004, d);
        do_read(12'h008, d2);
        checks++;
        if ({d2, d} !== 64'h0) begin
            errors++; $display("FAIL wrap_zero: got %h%h expected 0", d2, d);
        end
        do_read(12'h018, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL wrap_st_early: got %h expected 0", d);
        end
        @(posedge clk); #1;
        do_read(12'h018, d);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL wrap_st_set: got %h expected 1", d);
        end
        checks++;
        if (tim_int !== 1'b0) begin
            errors++; $display("FAIL wrap_int_early: got %b expected 0", tim_int);
        end
        @(posedge clk); #1;
        checks++;
        if (tim_int !== 1'b1) begin
            errors++; $display("FAIL wrap_int_set: got %b expected 1", tim_int);
        end
        do_write(12'h000, 32'h0, 4'hF, err);
    endtask

    task automatic test_clear_race();
        logic        err;
        logic [31:0] d;
        do_write(12'h004, 32'h0, 4'hF, err);
        do_write(12'h008, 32'h0, 4'hF, err);
        do_write(12'h018, 32'h1, 4'hF, err);
        do_read(12'h018, d);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL race_set_wins: got %h expected 1", d);
        end
        do_write(12'h00C, 32'h5, 4'hF, err);
        do_write(12'h018, 32'h0, 4'hF, err);
        do_read(12'h018, d);
        checks++;
        if (d !== 32'h1) begin
            errors++; $display("FAIL w0_no_effect: got %h expected 1", d);
        end
        do_write(12'h018, 32'h1, 4'hF, err);
        do_read(12'h018, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL w1c_clear: got %h expected 0", d);
        end
        checks++;
        if (tim_int !== 1'b1) begin
            errors++; $display("FAIL clr_int_lag: got %b expected 1", tim_int);
        end
        @(posedge clk); #1;
        checks++;
        if (tim_int !== 1'b0) begin
            errors++; $display("FAIL clr_int_drop: got %b expected 0", tim_int);
        end
    endtask

    task automatic test_back_to_back();
        logic        err;
        logic [31:0] d;
        do_write(12'h004, 32'h1122_3344, 4'hF, err);
        do_write(12'h000, 32'h0000_0001, 4'hF, err);
        do_write(12'h004, 32'hAABB_CC00, 4'b1110, err);
        do_read(12'h004, d);
        checks++;
        if (d !== 32'hAABB_CC44) begin
            errors++; $display("FAIL load_wins: got %h expected aabbcc44", d);
        end
        @(posedge clk); #1;
        do_read(12'h004, d);
        checks++;
        if (d !== 32'hAABB_CC45) begin
            errors++; $display("FAIL count_after_load: got %h expected aabbcc45", d);
        end
        do_write(12'h000, 32'h0, 4'hF, err);
    endtask

    task automatic test_reset_midop();
        logic        err;
        logic [31:0] d;
        do_write(12'h004, 32'h5, 4'hF, err);
        do_write(12'h008, 32'h0, 4'hF, err);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (tim_int !== 1'b1) begin
            errors++; $display("FAIL pre_reset_int: got %b expected 1", tim_int);
        end
        do_write(12'h010, 32'h0000_1234, 4'hF, err);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (tim_int !== 1'b0) begin
            errors++; $display("FAIL midrst_int: got %b expected 0", tim_int);
        end
        do_read(12'h010, d);
        checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL midrst_tcmp1: got %h expected ffffffff", d);
        end
        do_read(12'h000, d);
        checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL midrst_tcr: got %h expected 00000100", d);
        end
        do_read(12'h004, d);
        checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL midrst_tdr0: got %h expected 0", d);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_byte_strobes();
        test_prescaler();
        test_illegal_tcr();
        test_wrap();
        test_clear_race();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
